// File: rtl/cpu_skeleton_pkg.sv
// Shared definitions for the single-cycle processor system.
// Holds the memory/register geometry, the opcode set the core understands
// and the instruction ROM image.
package cpu_skeleton_pkg;
  localparam int ADDR_W    = 12;   // imem/dmem word-address width
  localparam int DATA_W    = 32;   // instruction, data and register width
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;

  // Instruction ROM image. Unlisted words are all-zero, which the core
  // treats as a no-op (R-type with a non-add funct writes nothing).
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
    case (addr)
      12'd0:   rom_word = 32'h2001_0005;  // addi $1,$0,5
      12'd1:   rom_word = 32'h2022_0003;  // addi $2,$1,3
      12'd2:   rom_word = 32'hac02_0000;  // sw   $2,0($0)
      12'd3:   rom_word = 32'h2000_0007;  // addi $0,$0,7
      default: rom_word = '0;
    endcase
  endfunction
endpackage

// File: rtl/cpu_skeleton_clock_divider.sv
// Board-clock divider for the processor/regfile domain.
// Ports:
//   i_clk        board clock
//   i_reset      synchronous active-high reset
//   o_div_clk    divided clock, MSB of the counter (50% duty, 2**DIV_LOG2 periods)
//   o_core_reset reset copy registered on i_clk, for the stopped-clock domains
module cpu_skeleton_clock_divider #(
  parameter int DIV_LOG2 = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_div_clk,
  output logic o_core_reset
);
  logic [DIV_LOG2-1:0] r_div_cnt;
  logic                r_core_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_div_cnt <= '0;
    else         r_div_cnt <= r_div_cnt + DIV_LOG2'(1);
  end

  // The divided clock is held low while reset is high, so the core and
  // register file can only clear asynchronously. Registering the reset on
  // the board clock keeps that clear net separate from the synchronous one
  // and makes its release line up with a board-clock edge, well before the
  // first divided rising edge.
  always_ff @(posedge i_clk) begin
    r_core_reset <= i_reset;
  end

  assign o_div_clk    = r_div_cnt[DIV_LOG2-1];
  assign o_core_reset = r_core_reset;
endmodule

// File: rtl/cpu_skeleton_dmem.sv
// Data RAM, 2**ADDR_W words, synchronous write and registered read.
// Ports: i_clk, i_address, i_data, i_wren, o_q.
module cpu_skeleton_dmem import cpu_skeleton_pkg::*; (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_wren,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_wren) r_mem[i_address] <= i_data;
    r_q <= r_mem[i_address];
  end

  assign o_q = r_q;
endmodule

// File: rtl/cpu_skeleton_imem.sv
// Instruction ROM with a registered read, clocked mid board-cycle.
// Ports: i_clk, i_address (word address), o_q (instruction).
module cpu_skeleton_imem import cpu_skeleton_pkg::*; (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    r_q <= rom_word(i_address);
  end

  assign o_q = r_q;
endmodule

// File: rtl/cpu_skeleton_processor.sv
// Single-cycle core: addi, lw, sw and R-type add. PC advances by one word
// per processor clock; there are no branches.
// Ports: i_clk/i_reset; imem address out / instruction in; dmem address,
// write data, write enable out / read data in; regfile control and write
// data out / two read data in.
module cpu_skeleton_processor import cpu_skeleton_pkg::*; (
  input  logic                 i_clk,
  input  logic                 i_reset,
  output logic [ADDR_W-1:0]    o_address_imem,
  input  logic [DATA_W-1:0]    i_q_imem,
  output logic [ADDR_W-1:0]    o_address_dmem,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_wren,
  input  logic [DATA_W-1:0]    i_q_dmem,
  output logic                 o_ctrl_write_en,
  output logic [REG_IDX_W-1:0] o_ctrl_write_reg,
  output logic [REG_IDX_W-1:0] o_ctrl_read_reg_a,
  output logic [REG_IDX_W-1:0] o_ctrl_read_reg_b,
  output logic [DATA_W-1:0]    o_data_write_reg,
  input  logic [DATA_W-1:0]    i_data_read_reg_a,
  input  logic [DATA_W-1:0]    i_data_read_reg_b
);
  logic [ADDR_W-1:0] r_pc;
  opcode_e           w_opcode;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_sum_imm;
  logic              w_unused;

  // Clock is stopped during reset, so the clear must be asynchronous.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_pc <= '0;
    else         r_pc <= r_pc + ADDR_W'(1);
  end

  assign o_address_imem    = r_pc;
  assign w_opcode          = opcode_e'(i_q_imem[31:26]);
  assign o_ctrl_read_reg_a = i_q_imem[25:21];
  assign o_ctrl_read_reg_b = i_q_imem[20:16];
  assign w_imm_sext        = {{(DATA_W-16){i_q_imem[15]}}, i_q_imem[15:0]};
  assign w_sum_imm         = i_data_read_reg_a + w_imm_sext;
  assign o_address_dmem    = w_sum_imm[ADDR_W-1:0];
  assign o_data            = i_data_read_reg_b;
  assign w_unused          = ^{w_sum_imm[DATA_W-1:ADDR_W], i_q_imem[10:6]};

  always_comb begin
    o_ctrl_write_en  = 1'b0;
    o_ctrl_write_reg = '0;
    o_data_write_reg = '0;
    o_wren           = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        if (i_q_imem[5:0] == FUNCT_ADD) begin
          o_ctrl_write_en  = 1'b1;
          o_ctrl_write_reg = i_q_imem[15:11];
          o_data_write_reg = i_data_read_reg_a + i_data_read_reg_b;
        end
      end
      OP_ADDI: begin
        o_ctrl_write_en  = 1'b1;
        o_ctrl_write_reg = i_q_imem[20:16];
        o_data_write_reg = w_sum_imm;
      end
      OP_LW: begin
        o_ctrl_write_en  = 1'b1;
        o_ctrl_write_reg = i_q_imem[20:16];
        o_data_write_reg = i_q_dmem;
      end
      OP_SW:   o_wren = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu_skeleton_regfile.sv
// 32 x DATA_W register file: two asynchronous read ports, one write port.
// r0 is never written and always reads zero.
// Ports: i_clk, i_reset, i_write_en, i_write_reg, i_read_reg_a/b,
// i_write_data, o_read_a/b.
module cpu_skeleton_regfile import cpu_skeleton_pkg::*; (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_write_en,
  input  logic [REG_IDX_W-1:0] i_write_reg,
  input  logic [REG_IDX_W-1:0] i_read_reg_a,
  input  logic [REG_IDX_W-1:0] i_read_reg_b,
  input  logic [DATA_W-1:0]    i_write_data,
  output logic [DATA_W-1:0]    o_read_a,
  output logic [DATA_W-1:0]    o_read_b
);
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Clock is stopped during reset, so the clear must be asynchronous.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_write_en && (i_write_reg != '0)) begin
      r_regs[i_write_reg] <= i_write_data;
    end
  end

  assign o_read_a = (i_read_reg_a == '0) ? '0 : r_regs[i_read_reg_a];
  assign o_read_b = (i_read_reg_b == '0) ? '0 : r_regs[i_read_reg_b];
endmodule

// File: rtl/cpu_skeleton.sv
// Top-level integration of the single-cycle processor system.
// Ports:
//   clock           board clock
//   reset           synchronous active-high reset
//   imem_clock      ~clock, instruction memory
//   dmem_clock      ~clock, data memory
//   processor_clock clock / 2**DIV_LOG2, core
//   regfile_clock   same as processor_clock, register file
module cpu_skeleton import cpu_skeleton_pkg::*; #(
  parameter int DIV_LOG2 = 2
) (
  input  logic clock,
  input  logic reset,
  output logic imem_clock,
  output logic dmem_clock,
  output logic processor_clock,
  output logic regfile_clock
);
  logic                 w_div_clk;
  logic                 w_core_reset;
  logic [ADDR_W-1:0]    w_address_imem;
  logic [DATA_W-1:0]    w_q_imem;
  logic [ADDR_W-1:0]    w_address_dmem;
  logic [DATA_W-1:0]    w_data;
  logic                 w_wren;
  logic [DATA_W-1:0]    w_q_dmem;
  logic                 w_ctrl_write_en;
  logic [REG_IDX_W-1:0] w_ctrl_write_reg;
  logic [REG_IDX_W-1:0] w_ctrl_read_reg_a;
  logic [REG_IDX_W-1:0] w_ctrl_read_reg_b;
  logic [DATA_W-1:0]    w_data_write_reg;
  logic [DATA_W-1:0]    w_data_read_reg_a;
  logic [DATA_W-1:0]    w_data_read_reg_b;

  cpu_skeleton_clock_divider #(.DIV_LOG2(DIV_LOG2)) u_divider (
    .i_clk(clock), .i_reset(reset), .o_div_clk(w_div_clk), .o_core_reset(w_core_reset)
  );

  // Memories capture on the falling board edge, mid-way between core edges.
  assign imem_clock      = ~clock;
  assign dmem_clock      = ~clock;
  assign processor_clock = w_div_clk;
  assign regfile_clock   = w_div_clk;

  cpu_skeleton_processor u_core (
    .i_clk(w_div_clk), .i_reset(w_core_reset),
    .o_address_imem(w_address_imem), .i_q_imem(w_q_imem),
    .o_address_dmem(w_address_dmem), .o_data(w_data), .o_wren(w_wren), .i_q_dmem(w_q_dmem),
    .o_ctrl_write_en(w_ctrl_write_en), .o_ctrl_write_reg(w_ctrl_write_reg),
    .o_ctrl_read_reg_a(w_ctrl_read_reg_a), .o_ctrl_read_reg_b(w_ctrl_read_reg_b),
    .o_data_write_reg(w_data_write_reg),
    .i_data_read_reg_a(w_data_read_reg_a), .i_data_read_reg_b(w_data_read_reg_b)
  );

  cpu_skeleton_imem u_imem (
    .i_clk(imem_clock), .i_address(w_address_imem), .o_q(w_q_imem)
  );

  cpu_skeleton_dmem u_dmem (
    .i_clk(dmem_clock), .i_address(w_address_dmem), .i_data(w_data),
    .i_wren(w_wren), .o_q(w_q_dmem)
  );

  cpu_skeleton_regfile u_regfile (
    .i_clk(w_div_clk), .i_reset(w_core_reset),
    .i_write_en(w_ctrl_write_en), .i_write_reg(w_ctrl_write_reg),
    .i_read_reg_a(w_ctrl_read_reg_a), .i_read_reg_b(w_ctrl_read_reg_b),
    .i_write_data(w_data_write_reg),
    .o_read_a(w_data_read_reg_a), .o_read_b(w_data_read_reg_b)
  );
endmodule

// File: tb/tb_cpu_skeleton.sv
module tb_cpu_skeleton;
  localparam int HALF_PERIOD = 10;
  localparam int DIV         = 4;   // divide-by-4 with default DIV_LOG2=2

  logic clock;
  logic reset;
  logic imem_clock;
  logic dmem_clock;
  logic processor_clock;
  logic regfile_clock;

  int checks   = 0;
  int failures = 0;
  int n_since_release = 0;   // posedges taken with reset low since last reset posedge

  time rise_q[$];
  time fall_q[$];

  cpu_skeleton dut (
    .clock(clock), .reset(reset),
    .imem_clock(imem_clock), .dmem_clock(dmem_clock),
    .processor_clock(processor_clock), .regfile_clock(regfile_clock)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #HALF_PERIOD clock = ~clock;
  end

  always @(posedge processor_clock) if ($time > 20) rise_q.push_back($time);
  always @(negedge processor_clock) if ($time > 20) fall_q.push_back($time);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Expected divided clock: high for the second half of each divide period
  // counted from the first posedge after reset release.
  task automatic check_clocks(input string tag);
    logic exp_div;
    exp_div = ((n_since_release % DIV) >= (DIV / 2));
    check({tag, "_proc"}, {31'b0, processor_clock}, {31'b0, exp_div});
    check({tag, "_rf"},   {31'b0, regfile_clock},   {31'b0, exp_div});
    check({tag, "_imem"}, {31'b0, imem_clock},      {31'b0, ~clock});
    check({tag, "_dmem"}, {31'b0, dmem_clock},      {31'b0, ~clock});
  endtask

  // One board cycle: check just after the posedge and just after the negedge.
  task automatic tick();
    logic rs;
    rs = reset;
    @(posedge clock);
    #1;
    if (rs) n_since_release = 0;
    else    n_since_release = n_since_release + 1;
    check_clocks("hi");
    #HALF_PERIOD;
    check_clocks("lo");
  endtask

  typedef struct {
    int is_store;
    int rt;
    int rs;
    int imm;
  } asm_t;

  asm_t prog[4];
  int   ref_regs[32];
  int   ref_mem0;

  initial begin
    int run_len;
    int rst_len;

    // 1. reset across first posedge
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_since_release = 0;
    check_clocks("rst");
    check("rst_proc_low", {31'b0, processor_clock}, 32'd0);

    // 2. release at 20 ns
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_clocks("rel");
    for (int i = 0; i < 8; i++) tick();

    // 3. mid-run reset while the divided clock is high
    for (int i = 0; i < DIV && ((n_since_release % DIV) < (DIV / 2)); i++) tick();
    check("pre_mid_rst_high", {31'b0, processor_clock}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_forced_low", {31'b0, processor_clock}, 32'd0);
    reset = 1'b0;
    tick();
    check("restart_first_edge_low", {31'b0, processor_clock}, 32'd0);
    tick();
    check("restart_second_edge_high", {31'b0, processor_clock}, 32'd1);

    // randomized run lengths and reset pulses
    for (int k = 0; k < 20; k++) begin
      run_len = $urandom_range(1, 9);
      rst_len = $urandom_range(1, 3);
      for (int i = 0; i < run_len; i++) tick();
      reset = 1'b1;
      for (int i = 0; i < rst_len; i++) tick();
      reset = 1'b0;
    end

    // 4/5. clean program run
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 200; i++) tick();

    prog[0] = '{is_store: 0, rt: 1, rs: 0, imm: 5};
    prog[1] = '{is_store: 0, rt: 2, rs: 1, imm: 3};
    prog[2] = '{is_store: 1, rt: 2, rs: 0, imm: 0};
    prog[3] = '{is_store: 0, rt: 0, rs: 0, imm: 7};
    for (int r = 0; r < 32; r++) ref_regs[r] = 0;
    ref_mem0 = 0;
    for (int p = 0; p < 4; p++) begin
      if (prog[p].is_store != 0) begin
        if (ref_regs[prog[p].rs] + prog[p].imm == 0) ref_mem0 = ref_regs[prog[p].rt];
      end else if (prog[p].rt != 0) begin
        ref_regs[prog[p].rt] = ref_regs[prog[p].rs] + prog[p].imm;
      end
    end
    check("reg_r0", dut.u_regfile.r_regs[0], ref_regs[0]);
    check("reg_r1", dut.u_regfile.r_regs[1], ref_regs[1]);
    check("reg_r2", dut.u_regfile.r_regs[2], ref_regs[2]);
    check("reg_r3", dut.u_regfile.r_regs[3], ref_regs[3]);
    check("dmem_0", dut.u_dmem.r_mem[0], ref_mem0);

    // edge timing after the first release
    check("rise_count", (rise_q.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
    check("fall_count", (fall_q.size() >= 1) ? 32'd1 : 32'd0, 32'd1);
    if (rise_q.size() >= 2 && fall_q.size() >= 1) begin
      check("first_rise_ns",  32'(rise_q[0]), 32'd50);
      check("first_fall_ns",  32'(fall_q[0]), 32'd90);
      check("second_rise_ns", 32'(rise_q[1]), 32'd130);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
